// File: rtl/operand_fetch.sv
// Operand-fetch stage for an RV32I add/sub/addi subset: register file with
// writeback bypass, decode, and a single-entry valid/ready output register.
module operand_fetch #(
  parameter bit CLEAR_RF_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        ex_ready,
  output logic        ex_valid,
  output logic [31:0] data_r1,
  output logic [31:0] data_r2,
  output logic        ALUControl,
  output logic [4:0]  ex_rd,
  output logic        ex_we,
  output logic        illegal
);

  logic [31:0] rf_q [32];
  logic [31:0] rf_d [32];

  logic        ex_valid_q, ex_valid_d;
  logic        illegal_q, illegal_d;
  logic [31:0] data_r1_q, data_r1_d;
  logic [31:0] data_r2_q, data_r2_d;
  logic        alu_control_q, alu_control_d;
  logic [4:0]  ex_rd_q, ex_rd_d;
  logic        ex_we_q, ex_we_d;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rs1, rs2, rd;
  logic        is_add, is_sub, is_addi, is_legal;
  logic        wb_hit, accept;
  logic [31:0] rs1_val, rs2_val, imm_sext;

  assign opcode   = instr[6:0];
  assign rd       = instr[11:7];
  assign funct3   = instr[14:12];
  assign rs1      = instr[19:15];
  assign rs2      = instr[24:20];
  assign funct7   = instr[31:25];
  assign imm_sext = {{20{instr[31]}}, instr[31:20]};

  assign is_add   = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0000000);
  assign is_sub   = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0100000);
  assign is_addi  = (opcode == 7'b0010011) && (funct3 == 3'b000);
  assign is_legal = is_add || is_sub || is_addi;

  assign wb_hit      = wb_en && (wb_rd != 5'd0);
  assign instr_ready = !ex_valid_q || ex_ready;
  assign accept      = instr_valid && instr_ready && !flush;

  // Reads forward the same-cycle writeback so the operand never sees a stale entry.
  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : (wb_hit && (wb_rd == rs1)) ? wb_data : rf_q[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : (wb_hit && (wb_rd == rs2)) ? wb_data : rf_q[rs2];

  always_comb begin
    rf_d = rf_q;
    if (wb_hit) begin
      rf_d[wb_rd] = wb_data;
    end
  end

  always_comb begin
    ex_valid_d    = ex_valid_q;
    illegal_d     = 1'b0;
    data_r1_d     = data_r1_q;
    data_r2_d     = data_r2_q;
    alu_control_d = alu_control_q;
    ex_rd_d       = ex_rd_q;
    ex_we_d       = ex_we_q;
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (accept) begin
      ex_valid_d    = is_legal;
      illegal_d     = !is_legal;
      data_r1_d     = rs1_val;
      data_r2_d     = is_addi ? imm_sext : rs2_val;
      alu_control_d = is_sub;
      ex_rd_d       = rd;
      ex_we_d       = is_legal && (rd != 5'd0);
    end else if (ex_ready) begin
      ex_valid_d = 1'b0;
    end
  end

  // Reset also blocks any writeback in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (CLEAR_RF_ON_RESET) begin
        for (int i = 0; i < 32; i++) begin
          rf_q[i] <= 32'd0;
        end
      end
    end else begin
      rf_q <= rf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q    <= 1'b0;
      illegal_q     <= 1'b0;
      data_r1_q     <= 32'd0;
      data_r2_q     <= 32'd0;
      alu_control_q <= 1'b0;
      ex_rd_q       <= 5'd0;
      ex_we_q       <= 1'b0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      illegal_q     <= illegal_d;
      data_r1_q     <= data_r1_d;
      data_r2_q     <= data_r2_d;
      alu_control_q <= alu_control_d;
      ex_rd_q       <= ex_rd_d;
      ex_we_q       <= ex_we_d;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign illegal    = illegal_q;
  assign data_r1    = data_r1_q;
  assign data_r2    = data_r2_q;
  assign ALUControl = alu_control_q;
  assign ex_rd      = ex_rd_q;
  assign ex_we      = ex_we_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed and randomized bench for operand_fetch against an
// instruction-level reference model of the register file and output stage.
module tb_operand_fetch;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ex_ready;
  logic        ex_valid;
  logic [31:0] data_r1;
  logic [31:0] data_r2;
  logic        ALUControl;
  logic [4:0]  ex_rd;
  logic        ex_we;
  logic        illegal;

  operand_fetch #(.CLEAR_RF_ON_RESET(1'b1)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd),
    .wb_data(wb_data), .ex_ready(ex_ready), .ex_valid(ex_valid),
    .data_r1(data_r1), .data_r2(data_r2), .ALUControl(ALUControl),
    .ex_rd(ex_rd), .ex_we(ex_we), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  bit skip_ready   = 1'b1;

  // Reference state: architectural registers plus what execute should see.
  logic [31:0] m_rf [32];
  bit          m_valid, m_illegal, m_known, m_alu, m_we;
  logic [31:0] m_r1, m_r2;
  logic [4:0]  m_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [4:0] rd);
    return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_addi(input logic [11:0] imm, input logic [4:0] rs1,
                                           input logic [4:0] rd);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] read_reg(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (wb_en && wb_rd == idx) return wb_data;
    return m_rf[idx];
  endfunction

  task automatic model_step();
    bit accept, legal, is_sub, is_addi;
    logic [31:0] imm;
    if (rst) begin
      m_valid = 0; m_illegal = 0; m_known = 1;
      m_r1 = 0; m_r2 = 0; m_alu = 0; m_rd = 0; m_we = 0;
      for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
      return;
    end
    accept  = instr_valid && (!m_valid || ex_ready) && !flush;
    is_sub  = instr[6:0] == 7'b0110011 && instr[14:12] == 3'b000 && instr[31:25] == 7'b0100000;
    is_addi = instr[6:0] == 7'b0010011 && instr[14:12] == 3'b000;
    legal   = is_sub || is_addi ||
              (instr[6:0] == 7'b0110011 && instr[14:12] == 3'b000 && instr[31:25] == 7'b0000000);
    imm     = 32'($signed(instr[31:20]));
    if (flush) begin
      m_valid = 0; m_illegal = 0;
    end else if (accept) begin
      m_valid = legal; m_illegal = !legal; m_known = legal;
      m_r1 = read_reg(instr[19:15]);
      m_r2 = is_addi ? imm : read_reg(instr[24:20]);
      m_alu = is_sub; m_rd = instr[11:7]; m_we = legal && instr[11:7] != 5'd0;
    end else begin
      m_illegal = 0;
      if (ex_ready) m_valid = 0;
    end
    if (wb_en && wb_rd != 5'd0) m_rf[wb_rd] = wb_data;
  endtask

  task automatic step();
    #1;
    if (!skip_ready) check("instr_ready", 32'(instr_ready), 32'(!m_valid || ex_ready));
    skip_ready = 1'b0;
    model_step();
    @(posedge clk);
    #1;
    check("ex_valid", 32'(ex_valid), 32'(m_valid));
    check("illegal", 32'(illegal), 32'(m_illegal));
    if (m_known) begin
      check("data_r1", data_r1, m_r1);
      check("data_r2", data_r2, m_r2);
      check("ALUControl", 32'(ALUControl), 32'(m_alu));
      check("ex_rd", 32'(ex_rd), 32'(m_rd));
      check("ex_we", 32'(ex_we), 32'(m_we));
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0] a, b, d;
    a = 5'($urandom_range(0, 31));
    b = 5'($urandom_range(0, 31));
    d = 5'($urandom_range(0, 31));
    case ($urandom_range(0, 4))
      0: return enc_r(7'b0000000, b, a, d);
      1: return enc_r(7'b0100000, b, a, d);
      2: return enc_addi(12'($urandom), a, d);
      3: return {7'b0, b, a, 3'b000, d, 7'b1100011};
      default: return {7'b0, b, a, 3'($urandom_range(1, 7)), d, 7'b0110011};
    endcase
  endfunction

  initial begin
    rst = 1; instr_valid = 0; instr = 0; flush = 0;
    wb_en = 0; wb_rd = 0; wb_data = 0; ex_ready = 1;
    m_valid = 0; m_illegal = 0; m_known = 0;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    @(negedge clk);
    step();
    check("reset_data_r1", data_r1, 32'd0);
    check("reset_ex_valid", 32'(ex_valid), 32'd0);

    rst = 0; wb_en = 1; wb_rd = 5'd5; wb_data = 32'h10; step();
    wb_rd = 5'd6; wb_data = 32'h3; step();

    wb_en = 0; instr_valid = 1; instr = enc_r(7'b0100000, 5'd6, 5'd5, 5'd7); step();
    check("sub_r1", data_r1, 32'h10);
    check("sub_r2", data_r2, 32'h3);
    check("sub_alu", 32'(ALUControl), 32'd1);
    check("sub_rd", 32'(ex_rd), 32'd7);
    check("sub_we", 32'(ex_we), 32'd1);

    instr = enc_addi(12'hFFF, 5'd0, 5'd1); step();
    check("addi_r1", data_r1, 32'd0);
    check("addi_r2", data_r2, 32'hFFFF_FFFF);
    check("addi_alu", 32'(ALUControl), 32'd0);

    instr = enc_r(7'b0, 5'd5, 5'd5, 5'd8);
    wb_en = 1; wb_rd = 5'd5; wb_data = 32'hDEAD_BEEF; step();
    check("bypass_r1", data_r1, 32'hDEAD_BEEF);
    check("bypass_r2", data_r2, 32'hDEAD_BEEF);

    wb_rd = 5'd0; wb_data = 32'h1234_5678; instr = enc_r(7'b0, 5'd0, 5'd0, 5'd9); step();
    wb_en = 0; step();
    check("x0_r1", data_r1, 32'd0);
    check("rd0_we", 32'(ex_we), 32'd1);

    instr = enc_r(7'b0, 5'd0, 5'd5, 5'd0); step();
    check("rd0_we_clear", 32'(ex_we), 32'd0);

    // Held operands must not pick up writes that land during the stall.
    ex_ready = 0; instr = enc_addi(12'h005, 5'd5, 5'd11);
    wb_en = 1; wb_rd = 5'd5; wb_data = 32'h55;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_ready", 32'(instr_ready), 32'd0);
      check("stall_r1", data_r1, 32'hDEAD_BEEF);
    end
    wb_en = 0; ex_ready = 1; step();
    check("resume_valid", 32'(ex_valid), 32'd1);
    check("resume_r1", data_r1, 32'h55);
    check("resume_r2", data_r2, 32'h5);

    instr = {7'b0, 5'd6, 5'd5, 3'b000, 5'd8, 7'b1100011}; step();
    check("branch_illegal", 32'(illegal), 32'd1);
    check("branch_valid", 32'(ex_valid), 32'd0);
    instr_valid = 0; step();
    check("illegal_pulse", 32'(illegal), 32'd0);

    instr_valid = 1; instr = enc_r(7'b0, 5'd6, 5'd5, 5'd12); step();
    ex_ready = 0; flush = 1; instr = enc_r(7'b0100000, 5'd6, 5'd5, 5'd13); step();
    check("flush_valid", 32'(ex_valid), 32'd0);
    check("flush_not_consumed", 32'(ex_rd), 32'd12);
    flush = 0; ex_ready = 1; instr_valid = 0; step();

    instr_valid = 1; instr = enc_r(7'b0, 5'd5, 5'd5, 5'd14); step();
    ex_ready = 0; step();
    rst = 1; wb_en = 1; wb_rd = 5'd5; wb_data = 32'hAAAA_0001; step();
    check("rst_valid", 32'(ex_valid), 32'd0);
    check("rst_r1", data_r1, 32'd0);
    check("rst_rd", 32'(ex_rd), 32'd0);
    rst = 0; wb_en = 0; ex_ready = 1; instr = enc_r(7'b0, 5'd5, 5'd5, 5'd15); step();
    check("rst_cleared_x5", data_r1, 32'd0);

    for (int n = 0; n < 400; n++) begin
      rst         = ($urandom_range(0, 63) == 0);
      flush       = ($urandom_range(0, 9) == 0);
      instr_valid = ($urandom_range(0, 9) < 7);
      ex_ready    = ($urandom_range(0, 9) < 6);
      wb_en       = ($urandom_range(0, 1) == 1);
      wb_rd       = 5'($urandom_range(0, 31));
      wb_data     = $urandom;
      instr       = rand_instr();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
